// File: rtl/idecoder_pkg.sv
// Shared class codes, RV32 base opcodes and the opcode-to-class mapping
// used by the decoder queue.
package idecoder_pkg;

    localparam int CLASS_W = 3;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NONE = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LSU  = 3'd2,
        CLS_BR   = 3'd3,
        CLS_SYS  = 3'd4,
        CLS_ILL  = 3'd7
    } instrClass_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Compressed encodings (low bits != 11) never match a listed opcode, so they land in ILL.
    function automatic instrClass_t opcodeClass(input logic [6:0] opcode);
        case (opcode)
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: return CLS_ALU;
            OP_LOAD, OP_STORE:               return CLS_LSU;
            OP_BRANCH, OP_JAL, OP_JALR:      return CLS_BR;
            OP_SYSTEM, OP_FENCE:             return CLS_SYS;
            default:                         return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/idecoder_classify.sv
// One-lane opcode classifier; an invalid lane always reports CLS_NONE.
module idecoder_classify
    import idecoder_pkg::*;
(
    input  logic [6:0]         opcode,
    input  logic               valid,
    output logic [CLASS_W-1:0] cls
);

    assign cls = valid ? opcodeClass(opcode) : CLS_NONE;

endmodule

// File: rtl/idecoder_queue.sv
// Decoder-stage buffer: holds one fetch entry, supports partial issue takes with
// realignment to lane 0, refills from the fetch FIFO once drained, tags lane classes.
module idecoder_queue
    import idecoder_pkg::*;
#(
    parameter int IW    = 32,
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iFlush,
    input  logic                  iRcvFifoEmpty,
    input  logic [IW*LANES-1:0]   iRcvInstrs,
    input  logic [LANES-1:0]      iRcvMask,
    output logic                  oReadFifo,
    output logic                  toIssue_vld,
    output logic [CW-1:0]         toIssue_cnt,
    output logic [IW*LANES-1:0]   toIssue_instrs,
    output logic [3*LANES-1:0]    toIssue_class,
    input  logic [CW-1:0]         fromIssue_take
);

    logic [IW-1:0] slotReg   [LANES];
    logic [IW-1:0] slotNext  [LANES];
    logic [IW-1:0] slotShift [LANES];
    logic [CW-1:0] occReg;
    logic [CW-1:0] occNext;
    logic [CW-1:0] tk;
    logic [CW-1:0] rem;
    logic [CW-1:0] maskCount;
    logic          vld;

    assign vld = (occReg != '0);

    // Issue may ask for more than is buffered; clamp to what is actually held.
    assign tk  = !vld ? '0 : ((fromIssue_take > occReg) ? occReg : fromIssue_take);
    assign rem = occReg - tk;

    assign oReadFifo = ~iFlush & ~iRcvFifoEmpty & (rem == '0);

    always_comb begin
        maskCount = '0;
        for (int i = 0; i < LANES; i++) begin
            maskCount = maskCount + CW'(iRcvMask[i]);
        end
    end

    // Leftovers slide down by tk lanes; vacated lanes are zeroed.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            slotShift[j] = '0;
            if (CW'(j) < rem) begin
                for (int k = 0; k < LANES - j; k++) begin
                    if (tk == CW'(k)) begin
                        slotShift[j] = slotReg[j + k];
                    end
                end
            end
        end
    end

    always_comb begin
        occNext  = occReg;
        slotNext = slotReg;
        if (iFlush) begin
            occNext = '0;
        end else if (oReadFifo) begin
            for (int i = 0; i < LANES; i++) begin
                slotNext[i] = iRcvInstrs[IW*i +: IW];
            end
            occNext = maskCount;
        end else begin
            slotNext = slotShift;
            occNext  = rem;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            occReg <= '0;
            for (int i = 0; i < LANES; i++) begin
                slotReg[i] <= '0;
            end
        end else begin
            occReg   <= occNext;
            slotReg  <= slotNext;
        end
    end

    assign toIssue_vld = vld;
    assign toIssue_cnt = occReg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic laneValid;
            assign laneValid = (CW'(gi) < occReg);
            assign toIssue_instrs[IW*gi +: IW] = laneValid ? slotReg[gi] : '0;

            idecoder_classify u_classify (
                .opcode (slotReg[gi][6:0]),
                .valid  (laneValid),
                .cls    (toIssue_class[CLASS_W*gi +: CLASS_W])
            );
        end
    endgenerate

    // Over-take is tolerated in hardware but flagged in simulation.
    assert property (@(posedge iClk) disable iff (iReset)
        !(vld && (fromIssue_take > occReg)))
        else $warning("idecoder_queue: take %0d exceeds count %0d, clamped", fromIssue_take, occReg);

    assert property (@(posedge iClk) disable iff (iReset)
        !(oReadFifo && ((iRcvMask & (iRcvMask + LANES'(1))) != '0)))
        else $warning("idecoder_queue: non-contiguous fetch mask %b popped", iRcvMask);

endmodule

// File: tb/tb_idecoder_queue.sv
// Bench for idecoder_queue: directed scenarios plus random traffic against a
// queue-based model, on a 4-lane and a 2-lane instance.
module tb_idecoder_queue;

    localparam int IW = 32;
    localparam logic [31:0] ADDI  = 32'h00000013;
    localparam logic [31:0] LW    = 32'h00002083;
    localparam logic [31:0] SW    = 32'h00102023;
    localparam logic [31:0] BEQ   = 32'h00000063;
    localparam logic [31:0] ECALL = 32'h00000073;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstA, flushA, emptyA, readA, vldA;
    logic [127:0] instrsA, outInstrsA;
    logic [3:0]   maskA;
    logic [2:0]   takeA, cntA;
    logic [11:0]  classA;

    logic         rstB, flushB, emptyB, readB, vldB;
    logic [63:0]  instrsB, outInstrsB;
    logic [1:0]   maskB, takeB, cntB;
    logic [5:0]   classB;

    idecoder_queue #(.IW(IW), .LANES(4)) dutA (
        .iClk(clk), .iReset(rstA), .iFlush(flushA), .iRcvFifoEmpty(emptyA),
        .iRcvInstrs(instrsA), .iRcvMask(maskA), .oReadFifo(readA),
        .toIssue_vld(vldA), .toIssue_cnt(cntA), .toIssue_instrs(outInstrsA),
        .toIssue_class(classA), .fromIssue_take(takeA)
    );

    idecoder_queue #(.IW(IW), .LANES(2)) dutB (
        .iClk(clk), .iReset(rstB), .iFlush(flushB), .iRcvFifoEmpty(emptyB),
        .iRcvInstrs(instrsB), .iRcvMask(maskB), .oReadFifo(readB),
        .toIssue_vld(vldB), .toIssue_cnt(cntB), .toIssue_instrs(outInstrsB),
        .toIssue_class(classB), .fromIssue_take(takeB)
    );

    int errors = 0;
    int checks = 0;

    // Model: the buffer is just an ordered list of pending instructions.
    logic [31:0] qA[$];
    logic [31:0] qB[$];

    logic [2:0]  expCnt, gotCnt;
    logic        expRead, gotRead, gotVld;
    logic [31:0] expInstr [4];
    logic [31:0] gotInstr [4];
    logic [2:0]  expClass [4];
    logic [2:0]  gotClass [4];

    int           curDut, pendTk;
    logic         pendFlush, pendPop;
    logic [127:0] pendInstrs;
    logic [3:0]   pendMask;

    logic [6:0] opTab [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                               7'h63, 7'h6F, 7'h67, 7'h73, 7'h0F};

    function automatic logic [2:0] refClass(input logic [31:0] ins);
        if (ins[1:0] != 2'b11) return 3'd7;
        case (ins[6:2])
            5'b01100, 5'b00100, 5'b01101, 5'b00101: return 3'd1;
            5'b00000, 5'b01000:                     return 3'd2;
            5'b11000, 5'b11011, 5'b11001:           return 3'd3;
            5'b11100, 5'b00011:                     return 3'd4;
            default:                                return 3'd7;
        endcase
    endfunction

    // Drive one cycle of inputs, compute expectations, and sample DUT at negedge.
    task automatic drive(input int dut, input logic flush, input logic empty,
                         input logic [127:0] instrs, input logic [3:0] mask, input int take);
        logic [31:0] q[$];
        int size;
        if (dut == 0) begin
            flushA = flush; emptyA = empty; instrsA = instrs; maskA = mask; takeA = 3'(take);
            q = qA;
        end else begin
            flushB = flush; emptyB = empty; instrsB = instrs[63:0]; maskB = mask[1:0]; takeB = 2'(take);
            q = qB;
        end
        size    = q.size();
        pendTk  = (take < size) ? take : size;
        expCnt  = 3'(size);
        expRead = !flush && !empty && (size == pendTk);
        for (int i = 0; i < 4; i++) begin
            expInstr[i] = (i < size) ? q[i] : 32'h0;
            expClass[i] = (i < size) ? refClass(q[i]) : 3'd0;
        end
        curDut = dut; pendFlush = flush; pendPop = expRead; pendInstrs = instrs; pendMask = mask;
        @(negedge clk);
        if (dut == 0) begin
            gotCnt = cntA; gotVld = vldA; gotRead = readA;
            for (int i = 0; i < 4; i++) begin
                gotInstr[i] = outInstrsA[32*i +: 32];
                gotClass[i] = classA[3*i +: 3];
            end
        end else begin
            gotCnt = {1'b0, cntB}; gotVld = vldB; gotRead = readB;
            for (int i = 0; i < 4; i++) begin
                gotInstr[i] = (i < 2) ? outInstrsB[32*i +: 32] : 32'h0;
                gotClass[i] = (i < 2) ? classB[3*i +: 3] : 3'd0;
            end
        end
    endtask

    task automatic advance();
        logic [31:0] q[$];
        @(posedge clk);
        #1;
        if (curDut == 0) q = qA; else q = qB;
        if (pendFlush) begin
            q.delete();
        end else if (pendPop) begin
            q.delete();
            for (int i = 0; i < $countones(pendMask); i++) q.push_back(pendInstrs[32*i +: 32]);
        end else begin
            repeat (pendTk) void'(q.pop_front());
        end
        if (curDut == 0) qA = q; else qB = q;
    endtask

    task automatic do_reset(input int dut);
        if (dut == 0) begin
            rstA = 1; flushA = 0; emptyA = 1; takeA = '0; maskA = '0;
        end else begin
            rstB = 1; flushB = 0; emptyB = 1; takeB = '0; maskB = '0;
        end
        @(posedge clk);
        #1;
        if (dut == 0) begin rstA = 0; qA.delete(); end
        else          begin rstB = 0; qB.delete(); end
    endtask

    task automatic test_reset();
        rstA = 1; flushA = 0; emptyA = 0; instrsA = {4{ADDI}}; maskA = 4'hF; takeA = '0;
        @(posedge clk);
        #1;
        rstA = 0;
        qA.delete();
        checks++; if (vldA !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vldA); end
        checks++; if (cntA !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cntA); end
        checks++; if (outInstrsA !== 128'h0) begin errors++; $display("FAIL reset_instrs: got %h expected 0", outInstrsA); end
        checks++; if (classA !== 12'h0) begin errors++; $display("FAIL reset_class: got %h expected 0", classA); end
        checks++; if (readA !== 1'b1) begin errors++; $display("FAIL reset_read: got %b expected 1", readA); end
    endtask

    task automatic test_full_take();
        do_reset(0);
        for (int c = 0; c < 6; c++) begin
            drive(0, 1'b0, 1'b0, {4{ADDI}}, 4'hF, 4);
            checks++; if (gotRead !== 1'b1) begin errors++; $display("FAIL full_read c%0d: got %b expected 1", c, gotRead); end
            checks++; if (gotCnt !== expCnt) begin errors++; $display("FAIL full_cnt c%0d: got %0d expected %0d", c, gotCnt, expCnt); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gotClass[i] !== expClass[i]) begin
                    errors++; $display("FAIL full_class c%0d l%0d: got %0d expected %0d", c, i, gotClass[i], expClass[i]);
                end
            end
            advance();
        end
    endtask

    task automatic test_partial();
        do_reset(0);
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'b0, 1'b0, {ECALL, BEQ, SW, LW}, 4'hF, 1);
            checks++; if (gotCnt !== expCnt) begin errors++; $display("FAIL part_cnt c%0d: got %0d expected %0d", c, gotCnt, expCnt); end
            checks++; if (gotRead !== expRead) begin errors++; $display("FAIL part_read c%0d: got %b expected %b", c, gotRead, expRead); end
            checks++; if (gotInstr[0] !== expInstr[0]) begin errors++; $display("FAIL part_lane0 c%0d: got %h expected %h", c, gotInstr[0], expInstr[0]); end
            checks++; if (gotClass[0] !== expClass[0]) begin errors++; $display("FAIL part_class0 c%0d: got %0d expected %0d", c, gotClass[0], expClass[0]); end
            advance();
        end
    endtask

    task automatic test_mask();
        do_reset(0);
        drive(0, 1'b0, 1'b0, {ADDI, ADDI, SW, LW}, 4'b0011, 0);
        advance();
        drive(0, 1'b0, 1'b1, '0, 4'b0000, 0);
        checks++; if (gotCnt !== 3'd2) begin errors++; $display("FAIL mask_cnt: got %0d expected 2", gotCnt); end
        for (int i = 2; i < 4; i++) begin
            checks++; if (gotInstr[i] !== 32'h0) begin errors++; $display("FAIL mask_instr l%0d: got %h expected 0", i, gotInstr[i]); end
            checks++; if (gotClass[i] !== 3'd0) begin errors++; $display("FAIL mask_class l%0d: got %0d expected 0", i, gotClass[i]); end
        end
        advance();
        drive(0, 1'b0, 1'b0, {4{ADDI}}, 4'b0000, 2);
        checks++; if (gotRead !== 1'b1) begin errors++; $display("FAIL mask0_pop: got %b expected 1", gotRead); end
        advance();
        drive(0, 1'b0, 1'b1, '0, 4'b0000, 0);
        checks++; if (gotVld !== 1'b0) begin errors++; $display("FAIL mask0_vld: got %b expected 0", gotVld); end
        checks++; if (gotCnt !== expCnt) begin errors++; $display("FAIL mask0_cnt: got %0d expected %0d", gotCnt, expCnt); end
        advance();
    endtask

    task automatic test_clamp();
        do_reset(0);
        drive(0, 1'b0, 1'b0, {ADDI, ADDI, BEQ, LW}, 4'b0011, 0);
        advance();
        drive(0, 1'b0, 1'b1, '0, 4'b0000, 5);
        checks++; if (gotCnt !== 3'd2) begin errors++; $display("FAIL clamp_cnt: got %0d expected 2", gotCnt); end
        advance();
        drive(0, 1'b0, 1'b1, '0, 4'b0000, 0);
        checks++; if (gotVld !== 1'b0) begin errors++; $display("FAIL clamp_empty: got %b expected 0", gotVld); end
        checks++; if (gotCnt !== expCnt) begin errors++; $display("FAIL clamp_cnt2: got %0d expected %0d", gotCnt, expCnt); end
        advance();
    endtask

    task automatic test_flush();
        do_reset(0);
        drive(0, 1'b0, 1'b0, {4{ADDI}}, 4'hF, 0);
        advance();
        drive(0, 1'b0, 1'b0, {4{ADDI}}, 4'hF, 1);
        advance();
        drive(0, 1'b1, 1'b0, {4{ADDI}}, 4'hF, 0);
        checks++; if (gotCnt !== 3'd3) begin errors++; $display("FAIL flush_pre_cnt: got %0d expected 3", gotCnt); end
        checks++; if (gotRead !== 1'b0) begin errors++; $display("FAIL flush_nopop: got %b expected 0", gotRead); end
        advance();
        drive(0, 1'b0, 1'b0, {4{ADDI}}, 4'hF, 0);
        checks++; if (gotVld !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b expected 0", gotVld); end
        checks++; if (gotRead !== 1'b1) begin errors++; $display("FAIL flush_resume: got %b expected 1", gotRead); end
        advance();
        drive(0, 1'b0, 1'b1, '0, 4'b0000, 0);
        checks++; if (gotCnt !== expCnt) begin errors++; $display("FAIL flush_refill: got %0d expected %0d", gotCnt, expCnt); end
        advance();
    endtask

    task automatic test_illegal();
        do_reset(0);
        drive(0, 1'b0, 1'b0, {BEQ, ADDI, 32'hFFFFFFFF, 32'h00000001}, 4'hF, 0);
        advance();
        drive(0, 1'b0, 1'b1, '0, 4'b0000, 0);
        checks++; if (gotClass[0] !== 3'd7) begin errors++; $display("FAIL ill_compressed: got %0d expected 7", gotClass[0]); end
        checks++; if (gotClass[1] !== 3'd7) begin errors++; $display("FAIL ill_ones: got %0d expected 7", gotClass[1]); end
        checks++; if (gotClass[3] !== expClass[3]) begin errors++; $display("FAIL ill_br: got %0d expected %0d", gotClass[3], expClass[3]); end
        advance();
    endtask

    task automatic test_random(input int dut, input int cycles);
        logic [127:0] ins;
        logic [31:0]  w;
        logic [3:0]   mask;
        int nL, k;
        nL = (dut == 0) ? 4 : 2;
        do_reset(dut);
        for (int c = 0; c < cycles; c++) begin
            ins = '0;
            for (int i = 0; i < nL; i++) begin
                w = $urandom;
                if ($urandom_range(0, 3) != 0) w[6:0] = opTab[$urandom_range(0, 10)];
                ins[32*i +: 32] = w;
            end
            k = $urandom_range(0, nL);
            mask = 4'((1 << k) - 1);
            drive(dut, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, ins, mask, $urandom_range(0, nL + 1));
            checks++; if (gotCnt !== expCnt) begin errors++; $display("FAIL rnd%0d_cnt c%0d: got %0d expected %0d", dut, c, gotCnt, expCnt); end
            checks++; if (gotVld !== (expCnt != 0)) begin errors++; $display("FAIL rnd%0d_vld c%0d: got %b expected %b", dut, c, gotVld, expCnt != 0); end
            checks++; if (gotRead !== expRead) begin errors++; $display("FAIL rnd%0d_read c%0d: got %b expected %b", dut, c, gotRead, expRead); end
            for (int i = 0; i < nL; i++) begin
                checks++;
                if (gotInstr[i] !== expInstr[i]) begin
                    errors++; $display("FAIL rnd%0d_instr c%0d l%0d: got %h expected %h", dut, c, i, gotInstr[i], expInstr[i]);
                end
                checks++;
                if (gotClass[i] !== expClass[i]) begin
                    errors++; $display("FAIL rnd%0d_class c%0d l%0d: got %0d expected %0d", dut, c, i, gotClass[i], expClass[i]);
                end
            end
            advance();
        end
    endtask

    task automatic test_lanes2();
        emptyA = 1; takeA = '0; flushA = 0;
        test_random(1, 200);
        do_reset(1);
        drive(1, 1'b0, 1'b0, {64'h0, SW, LW}, 4'b0011, 0);
        advance();
        drive(1, 1'b0, 1'b1, '0, 4'b0000, 1);
        checks++; if (gotCnt !== 3'd2) begin errors++; $display("FAIL l2_cnt: got %0d expected 2", gotCnt); end
        checks++; if (gotClass[1] !== 3'd2) begin errors++; $display("FAIL l2_class1: got %0d expected 2", gotClass[1]); end
        advance();
        drive(1, 1'b0, 1'b1, '0, 4'b0000, 0);
        checks++; if (gotInstr[0] !== SW) begin errors++; $display("FAIL l2_realign: got %h expected %h", gotInstr[0], SW); end
        checks++; if (gotCnt !== 3'd1) begin errors++; $display("FAIL l2_cnt1: got %0d expected 1", gotCnt); end
        advance();
    endtask

    initial begin
        rstA = 1; flushA = 0; emptyA = 1; instrsA = '0; maskA = '0; takeA = '0;
        rstB = 1; flushB = 0; emptyB = 1; instrsB = '0; maskB = '0; takeB = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_full_take();
        test_partial();
        test_mask();
        test_clamp();
        test_flush();
        test_illegal();
        test_random(0, 400);
        test_lanes2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
